// File: rtl/ref_row_sequencer.sv
// Refresh row walker: one memory slot per retention tick, row req/gnt handshake.
// Optional REF_WATCHDOG_EN aborts a starved request after GNT_TMO cycles.
module ref_row_sequencer #(
  parameter int NUM_MEMS   = 8,
  parameter int MEM_ADDR_W = 3,
  parameter int ROWS       = 32,
  parameter int ROW_W      = 5
`ifdef REF_WATCHDOG_EN
  ,
  parameter int GNT_TMO    = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ref_tick_i,
  input  logic [MEM_ADDR_W-1:0] ref_mem_addr_i,
  input  logic                  cycle_done_i,
  input  logic                  ref_gnt_i,
  output logic                  ref_req_o,
  output logic [ROW_W-1:0]      ref_row_o,
  output logic [NUM_MEMS-1:0]   ref_mem_sel_o,
  output logic                  any_ref_done_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [7:0]            cycle_cnt_o,
  output logic                  ref_timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [MEM_ADDR_W-1:0]   mem_q, mem_d;
  logic                    pend_q, pend_d;
  logic [7:0]              cnt_q, cnt_d;

  logic in_req;
  logic busy;
  logic xfer;
  logic trig;
  logic wd_fire;
  logic mem_ok;

  assign in_req = (state_q == S_REQ);
  assign busy   = (state_q != S_IDLE);
  assign xfer   = in_req & ref_gnt_i;
  assign trig   = ref_tick_i | pend_q;
  assign mem_ok = (32'(mem_q) < NUM_MEMS);

`ifdef REF_WATCHDOG_EN
  localparam int WD_W = $clog2(GNT_TMO + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Counts consecutive ungranted REQ cycles; zero outside REQ.
  always_comb begin
    wd_d = wd_q;
    if (!in_req || ref_gnt_i) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign wd_fire = in_req & ~ref_gnt_i &
                   (wd_q == WD_W'(GNT_TMO - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    mem_d   = mem_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;

    if (cycle_done_i && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          mem_d   = ref_mem_addr_i;
          row_d   = '0;
          // A tick landing while pending is consumed becomes the new pending.
          pend_d  = ref_tick_i & pend_q;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (wd_fire) begin
          state_d = S_DONE;
        end else if (xfer) begin
          if (row_q == LAST_ROW) begin
            state_d = S_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (busy && ref_tick_i && !pend_q) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      mem_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      mem_q   <= mem_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ref_req_o      = in_req;
  assign ref_row_o      = in_req ? row_q : '0;
  assign ref_mem_sel_o  = (in_req && mem_ok) ?
                          (NUM_MEMS'(1) << mem_q) : '0;
  assign any_ref_done_o = (state_q == S_DONE);
  assign busy_o         = busy;
  assign overrun_o      = ~rst & busy & ref_tick_i & pend_q;
  assign cycle_cnt_o    = cnt_q;
  assign ref_timeout_o  = ~rst & wd_fire;

endmodule

// File: tb/tb_ref_row_sequencer.sv
// Bench for ref_row_sequencer: slot-position model plus directed scenarios.
module tb_ref_row_sequencer;

  localparam int NUM_MEMS   = 8;
  localparam int MEM_ADDR_W = 3;
  localparam int ROWS       = 32;
  localparam int ROW_W      = 5;
  localparam int GNT_TMO    = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  tick = 1'b0;
  logic [MEM_ADDR_W-1:0] addr = '0;
  logic                  cdone = 1'b0;
  logic                  gnt = 1'b0;

  logic                  ref_req_o;
  logic [ROW_W-1:0]      ref_row_o;
  logic [NUM_MEMS-1:0]   ref_mem_sel_o;
  logic                  any_ref_done_o;
  logic                  busy_o;
  logic                  overrun_o;
  logic [7:0]            cycle_cnt_o;
  logic                  ref_timeout_o;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model: m_pos = -1 idle, 0..ROWS-1 requesting that row, ROWS = done cycle.
  int m_pos = -1;
  bit m_pend = 1'b0;
  int m_mem = 0;
  int m_cnt = 0;
  int m_stall = 0;

  always #5 clk = ~clk;

  ref_row_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .ref_tick_i     (tick),
    .ref_mem_addr_i (addr),
    .cycle_done_i   (cdone),
    .ref_gnt_i      (gnt),
    .ref_req_o      (ref_req_o),
    .ref_row_o      (ref_row_o),
    .ref_mem_sel_o  (ref_mem_sel_o),
    .any_ref_done_o (any_ref_done_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .ref_timeout_o  (ref_timeout_o)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_timeout();
`ifdef REF_WATCHDOG_EN
    return m_pos >= 0 && m_pos < ROWS && !gnt && m_stall == GNT_TMO - 1;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pos = -1;
      m_pend = 1'b0;
      m_cnt = 0;
      m_stall = 0;
    end else begin
      if (cdone && m_cnt < 255) m_cnt++;
      if (m_pos == -1) begin
        if (tick || m_pend) begin
          m_mem = int'(addr);
          m_pos = 0;
          m_pend = tick && m_pend;
          m_stall = 0;
        end
      end else begin
        if (tick && !m_pend) m_pend = 1'b1;
        if (m_pos == ROWS) m_pos = -1;
        else if (m_timeout()) m_pos = ROWS;
        else if (gnt) begin
          m_pos = m_pos + 1;
          m_stall = 0;
        end else m_stall++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit req_e;
      bit busy_e;
      req_e  = (m_pos >= 0 && m_pos < ROWS);
      busy_e = (m_pos != -1);
      chk("m_req", 32'(ref_req_o), 32'(req_e));
      chk("m_row", 32'(ref_row_o), req_e ? m_pos : 0);
      chk("m_sel", 32'(ref_mem_sel_o),
          (req_e && m_mem < NUM_MEMS) ? (32'd1 << m_mem) : 32'd0);
      chk("m_done", 32'(any_ref_done_o), 32'(m_pos == ROWS));
      chk("m_busy", 32'(busy_o), 32'(busy_e));
      chk("m_ovr", 32'(overrun_o), 32'(!rst && busy_e && tick && m_pend));
      chk("m_cnt", 32'(cycle_cnt_o), m_cnt);
      chk("m_tmo", 32'(ref_timeout_o), 32'(!rst && m_timeout()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy_o && k < 200) begin
      cyc();
      k++;
    end
    chk("idle_bound", 32'(k < 200), 32'd1);
  endtask

  initial begin
    int done_n;
    int done_at;
    int rows_ok;
    int cnt_a;
    int cnt_b;

    rst = 1'b1;
    cyc();
    cmp_en = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(ref_req_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_cnt", 32'(cycle_cnt_o), 0);
    chk("rst_sel", 32'(ref_mem_sel_o), 0);
    chk("rst_done", 32'(any_ref_done_o), 0);

    // Full slot, constant grant
    addr = 3'd3;
    gnt = 1'b1;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    done_n = 0;
    done_at = 0;
    rows_ok = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) chk("full_sel", 32'(ref_mem_sel_o), 32'h08);
      if (ref_req_o && ref_row_o == ROW_W'(i - 1)) rows_ok++;
      if (any_ref_done_o) begin
        done_n++;
        done_at = i;
      end
      cyc();
    end
    chk("full_rows", rows_ok, 32);
    chk("full_done_n", done_n, 1);
    chk("full_done_cycle", done_at + 1, 34);

    // Stall at row 7
    addr = 3'd5;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (7) cyc();
    gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_row", 32'(ref_row_o), 7);
      chk("stall_req", 32'(ref_req_o), 1);
      cyc();
    end
    gnt = 1'b1;
    @(negedge clk);
    chk("stall_row_gnt", 32'(ref_row_o), 7);
    cyc();
    @(negedge clk);
    chk("stall_row_next", 32'(ref_row_o), 8);
    wait_idle();

    // Overrun, pending slot, latched memory
    addr = 3'd2;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    addr = 3'd6;
    repeat (3) cyc();
    tick = 1'b1;
    @(negedge clk);
    chk("ovr_first", 32'(overrun_o), 0);
    cyc();
    tick = 1'b0;
    cyc();
    tick = 1'b1;
    @(negedge clk);
    chk("ovr_second", 32'(overrun_o), 1);
    cyc();
    tick = 1'b0;
    done_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (any_ref_done_o) begin
        done_n = 1;
        break;
      end
      if (ref_req_o) chk("ovr_sel_held", 32'(ref_mem_sel_o), 32'h04);
      cyc();
    end
    chk("ovr_done_seen", done_n, 1);
    cyc();
    @(negedge clk);
    chk("ovr_gap_idle", 32'(busy_o), 0);
    cyc();
    @(negedge clk);
    chk("ovr_slot2_req", 32'(ref_req_o), 1);
    chk("ovr_slot2_sel", 32'(ref_mem_sel_o), 32'h40);
    chk("ovr_slot2_row", 32'(ref_row_o), 0);
    wait_idle();
    repeat (5) cyc();
    chk("ovr_no_third", 32'(busy_o), 0);

    // Saturating cycle counter
    cdone = 1'b1;
    repeat (100) cyc();
    @(negedge clk);
    cnt_a = int'(cycle_cnt_o);
    chk("cnt_100", cnt_a, 100);
    repeat (200) cyc();
    cdone = 1'b0;
    @(negedge clk);
    cnt_b = int'(cycle_cnt_o);
    chk("cnt_sat", cnt_b, 255);

    // Reset mid-slot at row 10
    addr = 3'd1;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_row", 32'(ref_row_o), 10);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy_o), 0);
    chk("mid_cnt", 32'(cycle_cnt_o), 0);
    done_n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (any_ref_done_o) done_n++;
      cyc();
    end
    chk("mid_no_done", done_n, 0);

    // Grant stuck low
    addr = 3'd7;
    gnt = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
`ifdef REF_WATCHDOG_EN
    done_at = 0;
    cnt_a = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ref_timeout_o) cnt_a = i;
      if (any_ref_done_o) done_at = i;
      cyc();
    end
    chk("wd_tmo_at", cnt_a, 16);
    chk("wd_done_at", done_at, 17);
`else
    rows_ok = 0;
    cnt_a = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ref_req_o && ref_row_o == '0) rows_ok++;
      if (ref_timeout_o || any_ref_done_o) cnt_a++;
      cyc();
    end
    chk("stuck_req", rows_ok, 40);
    chk("stuck_no_tmo", cnt_a, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
`endif
    gnt = 1'b1;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
